spi_target: RTL and testbench
=============================

Name: spi_target

Overview:
- SPI responder (mode 0, MSB first, 8-bit frames). It lets an external SPI host exchange bytes with tinyQV through the memory-mapped peripheral bus.
- It is the target-side counterpart of the existing SPI controller and sits beside it in the peripheral map.
- All SPI pins are asynchronous to clk. They are oversampled and synchronised inside the block.
- It provides a one-byte TX holding buffer, a one-byte RX buffer, and an overrun flag.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each of spi_cs_n, spi_sck and spi_mosi (minimum 2).
- IDLE_MISO, 1'b1: value shifted out when no TX byte is loaded at frame start (the byte sent is {8{IDLE_MISO}}).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- spi_cs_n  in  1  target select from host, active low.
- spi_sck  in  1  serial clock from host; frequency must be ≤ clk/8.
- spi_mosi  in  1  host-to-target data.
- spi_miso  out  1  target-to-host data.
- spi_miso_oe  out  1  high while the synchronised cs_n is low.
- tx_wr  in  1  one-cycle strobe: write tx_data into the TX holding buffer.
- tx_data  in  8  byte to transmit.
- tx_full  out  1  TX holding buffer occupied (not yet moved into the shifter).
- rx_rd  in  1  one-cycle strobe: consume rx_data.
- rx_data  out  8  last complete received byte.
- rx_valid  out  1  rx_data unread.
- overrun  out  1  sticky: a byte completed while rx_valid was already set.
- overrun_clr  in  1  clears overrun.
- busy  out  1  frame active (state SHIFT).

Behaviour:
- Reset values:
  - spi_miso = IDLE_MISO.
  - spi_miso_oe, tx_full, rx_valid, overrun, busy = 0.
  - rx_data = 8'h00.
  - Shifters = 0, bit_cnt = 0, state = IDLE.
- Synchronisers reset to cs_n = 1, sck = 0, mosi = 0.
- Edge detection: compare each last sync stage with its previous-cycle value. An edge is acted on in the cycle it is detected. Pin-to-action latency is SYNC_STAGES+1 clk.
- State IDLE (cs_n_s high):
  - On cs_n_s falling, go to SHIFT with bit_cnt = 0.
  - Load tx_shift from the holding buffer if tx_full, and clear tx_full in the same cycle; otherwise load {8{IDLE_MISO}}.
  - spi_miso = tx_shift[7] from that cycle on.
- State SHIFT:
  - sck rising: rx_shift <= {rx_shift[6:0], mosi_s}; bit_cnt++.
  - At bit_cnt wrap 7→0:
    - rx_data <= the completed byte and rx_valid <= 1 on the same edge.
    - If rx_valid was already 1 and rx_rd is not asserted that cycle, set overrun. rx_data is overwritten with the new byte either way.
  - sck falling:
    - If bit_cnt != 0: tx_shift <= tx_shift << 1.
    - If bit_cnt == 0 (byte boundary, back-to-back frames): reload tx_shift from the buffer as at frame start.
  - The first falling edge after cs_n assert is ignored (bit_cnt == 0 and no bits yet); a byte_started flag tracks this.
  - cs_n_s rising returns to IDLE.
- cs_n deassert mid-byte:
  - Partial rx bits are discarded; rx_valid and rx_data are untouched.
  - A TX byte already in the shifter is lost. The holding buffer is unaffected.
- Simultaneous events:
  - rx_rd in the same cycle a byte completes: rx_valid stays 1, no overrun.
  - tx_wr in the same cycle as a reload from a full buffer: the reload takes the old byte and the new byte fills the buffer; tx_full stays 1.
  - tx_wr while tx_full and no reload: overwrites the buffered byte.
  - overrun_clr together with a new overrun: set wins.
- spi_miso_oe = !cs_n_s. spi_miso holds its value in IDLE.
- Reset asserted mid-frame: everything returns to reset values immediately. The block resumes at the next cs_n falling edge seen after rst deasserts.

Optional Feature:
- Macro SPI_TARGET_MODE3_EN.
- When defined:
  - Adds input port `mode3` (1 bit, sampled only in IDLE).
  - mode3 = 1 selects CPOL = 1, CPHA = 1: sample on rising, shift on falling, idle sck high. The sck synchroniser resets to 1.
  - The first-falling-edge ignore rule applies to the leading edge in mode 3.
- When undefined: no port; mode 0 only, as above.

Decomposition:
- Shared header spi_target_defs.vh contains:
  - State encodings ST_IDLE and ST_SHIFT.
  - Peripheral register offsets PERI_SPI_TGT_DATA and PERI_SPI_TGT_STATUS. The status bit layout is {overrun, busy, rx_valid, tx_full}.
- One sub-module, sync_edge: SYNC_STAGES synchroniser plus registered previous value. Outputs level, rise, fall. Instantiated three times.

Test Plan:
- Single byte: tx_wr 8'hA5, then the host sends 8'h3C at clk/8 → host receives 8'hA5; rx_data = 8'h3C, rx_valid = 1, tx_full = 0, overrun = 0.
- Empty TX: no tx_wr, host sends 8'h01 → host receives 8'hFF; rx_data = 8'h01.
- Back-to-back, cs_n held low: buffer 8'h11, then tx_wr 8'h22 during byte 1; host sends 8'hAA, 8'h55 → host receives 8'h11, 8'h22. No rx_rd is issued → overrun = 1, rx_data = 8'h55.
- Abort: cs_n rises after 5 bits → rx_valid unchanged, busy = 0. The next full frame with 8'h77 gives rx_data = 8'h77.
- Async reset mid-frame (rst pulse after 3 bits) → all outputs at reset values within the same cycle. The next frame works normally.
- With SPI_TARGET_MODE3_EN and mode3 = 1: sck idles high, host sends 8'hC3 → rx_data = 8'hC3; host receives the buffered 8'h5A.

Source files
------------

// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared definitions for the SPI target block.
//   - FSM state encodings (ST_IDLE, ST_SHIFT)
//   - peripheral register offsets and the status word layout
package spi_target_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } spi_tgt_state_e;

   localparam logic [5:0] PERI_SPI_TGT_DATA   = 6'h00;
   localparam logic [5:0] PERI_SPI_TGT_STATUS = 6'h04;

   // Status register: {overrun, busy, rx_valid, tx_full}
   localparam int STAT_TX_FULL  = 0;
   localparam int STAT_RX_VALID = 1;
   localparam int STAT_BUSY     = 2;
   localparam int STAT_OVERRUN  = 3;

   function automatic logic [3:0] spi_tgt_status(input logic overrun, input logic busy,
                                                 input logic rx_valid, input logic tx_full);
      return {overrun, busy, rx_valid, tx_full};
   endfunction

endpackage

// File: rtl/spi_target_sync_edge.sv
// sync_edge: multi-stage synchroniser for one asynchronous pin, plus a
// registered copy of the last stage for edge detection.
// Ports:
//   clk, rst      system clock, async active-high reset
//   d             asynchronous input pin
//   level         synchronised level (last stage)
//   rise, fall    one-cycle pulses when level changes
// Parameters: STAGES (>= 2), RST_VAL (reset value of every stage).
module sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_target.sv
// spi_target: SPI responder (mode 0, MSB first, 8-bit frames) for the
// peripheral bus. SPI pins are asynchronous and are synchronised here.
// Ports:
//   clk, rst                 system clock, async active-high reset
//   spi_cs_n/sck/mosi        host pins (async)
//   spi_miso, spi_miso_oe    target data out and its enable
//   tx_wr, tx_data, tx_full  one-byte TX holding buffer
//   rx_rd, rx_data, rx_valid one-byte RX buffer
//   overrun, overrun_clr     sticky RX overrun flag
//   busy                     frame in progress
// Optional: SPI_TARGET_MODE3_EN adds input mode3 (CPOL=1/CPHA=1, sck idles
// high). Sampling stays on sck rising and shifting on sck falling; the
// leading falling edge of a mode-3 byte is absorbed by the byte_started rule.
//
// state    | meaning
// ST_IDLE  | cs_n high, waiting for cs_n falling; spi_miso holds
// ST_SHIFT | frame active: sample on sck rise, shift/reload on sck fall
module spi_target
   import spi_target_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter logic IDLE_MISO   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
`ifdef SPI_TARGET_MODE3_EN
   input  logic       mode3,
`endif
   input  logic       spi_cs_n,
   input  logic       spi_sck,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       spi_miso_oe,
   input  logic       tx_wr,
   input  logic [7:0] tx_data,
   output logic       tx_full,
   input  logic       rx_rd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       overrun,
   input  logic       overrun_clr,
   output logic       busy
);

`ifdef SPI_TARGET_MODE3_EN
   localparam logic SCK_RST = 1'b1;
`else
   localparam logic SCK_RST = 1'b0;
`endif

   logic cs_n_s, cs_rise, cs_fall;
   logic sck_rise, sck_fall;
   logic mosi_s;
   logic unused_sync;
   logic sck_s_unused, mosi_rise_unused, mosi_fall_unused;

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst(rst), .d(spi_cs_n), .level(cs_n_s), .rise(cs_rise), .fall(cs_fall));
   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SCK_RST)) u_sync_sck (
      .clk(clk), .rst(rst), .d(spi_sck), .level(sck_s_unused), .rise(sck_rise), .fall(sck_fall));
   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .d(spi_mosi), .level(mosi_s), .rise(mosi_rise_unused),
      .fall(mosi_fall_unused));

   spi_tgt_state_e state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       byte_started_q, byte_started_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] tx_buf_q, tx_buf_d;
   logic       tx_full_q, tx_full_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       overrun_q, overrun_d;
   logic       miso_q, miso_d;
   logic       reload, byte_done;

`ifdef SPI_TARGET_MODE3_EN
   logic mode3_q, mode3_d;
   logic mode3_unused;
   assign mode3_unused = mode3_q;
   always_comb begin
      mode3_d = (state_q == ST_IDLE) ? mode3 : mode3_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mode3_q <= 1'b0;
      else     mode3_q <= mode3_d;
   end
`endif

   assign unused_sync = sck_s_unused | mosi_rise_unused | mosi_fall_unused;

   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      byte_started_d = byte_started_q;
      rx_shift_d     = rx_shift_q;
      tx_shift_d     = tx_shift_q;
      tx_buf_d       = tx_buf_q;
      tx_full_d      = tx_full_q;
      rx_data_d      = rx_data_q;
      rx_valid_d     = rx_valid_q;
      overrun_d      = overrun_q;
      miso_d         = miso_q;
      reload         = 1'b0;
      byte_done      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d        = ST_SHIFT;
               bit_cnt_d      = 3'd0;
               byte_started_d = 1'b0;
               rx_shift_d     = 8'h00;
               reload         = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (cs_rise) begin
               // Abort: partial RX bits and any TX byte in the shifter are dropped.
               state_d        = ST_IDLE;
               bit_cnt_d      = 3'd0;
               byte_started_d = 1'b0;
            end else if (sck_rise) begin
               rx_shift_d     = {rx_shift_q[6:0], mosi_s};
               bit_cnt_d      = bit_cnt_q + 3'd1;
               byte_started_d = 1'b1;
               byte_done      = (bit_cnt_q == 3'd7);
            end else if (sck_fall) begin
               if (bit_cnt_q != 3'd0)  tx_shift_d = {tx_shift_q[6:0], 1'b0};
               else if (byte_started_q) reload    = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (reload) begin
         tx_shift_d = tx_full_q ? tx_buf_q : {8{IDLE_MISO}};
         tx_full_d  = 1'b0;
      end
      // A write in the reload cycle lands in the freshly emptied buffer.
      if (tx_wr) begin
         tx_buf_d  = tx_data;
         tx_full_d = 1'b1;
      end

      if (state_d == ST_SHIFT) miso_d = tx_shift_d[7];

      if (rx_rd) rx_valid_d = 1'b0;
      if (overrun_clr) overrun_d = 1'b0;
      if (byte_done) begin
         rx_data_d  = {rx_shift_q[6:0], mosi_s};
         rx_valid_d = 1'b1;
         if (rx_valid_q && !rx_rd) overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         bit_cnt_q      <= 3'd0;
         byte_started_q <= 1'b0;
         rx_shift_q     <= 8'h00;
         tx_shift_q     <= 8'h00;
         tx_buf_q       <= 8'h00;
         tx_full_q      <= 1'b0;
         rx_data_q      <= 8'h00;
         rx_valid_q     <= 1'b0;
         overrun_q      <= 1'b0;
         miso_q         <= IDLE_MISO;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         byte_started_q <= byte_started_d;
         rx_shift_q     <= rx_shift_d;
         tx_shift_q     <= tx_shift_d;
         tx_buf_q       <= tx_buf_d;
         tx_full_q      <= tx_full_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         overrun_q      <= overrun_d;
         miso_q         <= miso_d;
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = ~cs_n_s;
   assign tx_full     = tx_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign overrun     = overrun_q;
   assign busy        = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_target.sv
module tb_spi_target;

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_cs_n, spi_sck, spi_mosi;
   logic       spi_miso, spi_miso_oe;
   logic       tx_wr;
   logic [7:0] tx_data;
   logic       tx_full;
   logic       rx_rd;
   logic [7:0] rx_data;
   logic       rx_valid, overrun, overrun_clr, busy;
`ifdef SPI_TARGET_MODE3_EN
   logic       mode3;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   spi_target dut (
      .clk(clk), .rst(rst),
`ifdef SPI_TARGET_MODE3_EN
      .mode3(mode3),
`endif
      .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
      .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid),
      .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy));

   typedef struct {
      logic [7:0] host_tx;
      logic       do_wr;
      logic [7:0] wr_byte;
      logic [7:0] exp_host_rx;
      logic [7:0] exp_rx_data;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", nm, act, exp);
      end
   endtask

   // Half sck period: 4 clk, i.e. sck = clk/8.
   task automatic half();
      repeat (4) @(negedge clk);
   endtask

   task automatic write_tx(input logic [7:0] b);
      @(negedge clk);
      tx_wr = 1'b1; tx_data = b;
      @(negedge clk);
      tx_wr = 1'b0;
   endtask

   task automatic pulse_rx_rd();
      @(negedge clk); rx_rd = 1'b1;
      @(negedge clk); rx_rd = 1'b0;
   endtask

   // Shift nbits MSB-first; optional tx_wr in the middle (bit index 3).
   task automatic xfer(input logic cpol, input logic [7:0] mo, input int nbits,
                       input logic wr_mid, input logic [7:0] wr_b, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         if (cpol) spi_sck = 1'b0;
         spi_mosi = mo[7-i];
         if (wr_mid && i == 3) begin
            tx_wr = 1'b1; tx_data = wr_b;
            @(negedge clk);
            tx_wr = 1'b0;
            repeat (3) @(negedge clk);
         end else begin
            half();
         end
         mi[7-i] = spi_miso;
         spi_sck = 1'b1;
         half();
         if (!cpol) spi_sck = 1'b0;
      end
   endtask

   task automatic frame(input logic cpol, input logic [7:0] mo, output logic [7:0] mi);
      spi_cs_n = 1'b0;
      half();
      xfer(cpol, mo, 8, 1'b0, 8'h00, mi);
      half();
      spi_cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   logic [7:0] got, got2, prev_rx;

   initial begin
      rst = 1'b1; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
      tx_wr = 1'b0; tx_data = 8'h00; rx_rd = 1'b0; overrun_clr = 1'b0;
`ifdef SPI_TARGET_MODE3_EN
      mode3 = 1'b0;
`endif
      vecs[0] = '{8'h3C, 1'b1, 8'hA5, 8'hA5, 8'h3C};
      vecs[1] = '{8'h01, 1'b0, 8'h00, 8'hFF, 8'h01};
      vecs[2] = '{8'h80, 1'b1, 8'h5A, 8'h5A, 8'h80};
      vecs[3] = '{8'hFF, 1'b1, 8'h00, 8'h00, 8'hFF};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_miso",    {7'b0, spi_miso},    8'h01);
      chk("rst_oe",      {7'b0, spi_miso_oe}, 8'h00);
      chk("rst_tx_full", {7'b0, tx_full},     8'h00);
      chk("rst_rx_valid",{7'b0, rx_valid},    8'h00);
      chk("rst_overrun", {7'b0, overrun},     8'h00);
      chk("rst_busy",    {7'b0, busy},        8'h00);
      chk("rst_rx_data", rx_data,             8'h00);

      for (int v = 0; v < 4; v++) begin
         pulse_rx_rd();
         if (vecs[v].do_wr) begin
            write_tx(vecs[v].wr_byte);
            chk($sformatf("v%0d_tx_full_pre", v), {7'b0, tx_full}, 8'h01);
         end
         frame(1'b0, vecs[v].host_tx, got);
         chk($sformatf("v%0d_host_rx", v),  got,                 vecs[v].exp_host_rx);
         chk($sformatf("v%0d_rx_data", v),  rx_data,             vecs[v].exp_rx_data);
         chk($sformatf("v%0d_rx_valid", v), {7'b0, rx_valid},    8'h01);
         chk($sformatf("v%0d_tx_full", v),  {7'b0, tx_full},     8'h00);
         chk($sformatf("v%0d_overrun", v),  {7'b0, overrun},     8'h00);
         chk($sformatf("v%0d_busy", v),     {7'b0, busy},        8'h00);
      end

      // Back-to-back bytes with cs held low, buffer refilled during byte 1.
      pulse_rx_rd();
      write_tx(8'h11);
      spi_cs_n = 1'b0;
      half();
      xfer(1'b0, 8'hAA, 8, 1'b1, 8'h22, got);
      chk("b2b_busy_mid", {7'b0, busy}, 8'h01);
      chk("b2b_oe_mid",   {7'b0, spi_miso_oe}, 8'h01);
      xfer(1'b0, 8'h55, 8, 1'b0, 8'h00, got2);
      half();
      spi_cs_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("b2b_host_rx1", got,  8'h11);
      chk("b2b_host_rx2", got2, 8'h22);
      chk("b2b_overrun",  {7'b0, overrun}, 8'h01);
      chk("b2b_rx_data",  rx_data, 8'h55);
      chk("b2b_tx_full",  {7'b0, tx_full}, 8'h00);

      // overrun_clr is sticky-cleared.
      @(negedge clk); overrun_clr = 1'b1;
      @(negedge clk); overrun_clr = 1'b0;
      chk("ovr_clr", {7'b0, overrun}, 8'h00);

      // tx_wr while full overwrites the buffered byte.
      pulse_rx_rd();
      write_tx(8'h12);
      write_tx(8'h34);
      frame(1'b0, 8'h9C, got);
      chk("ovw_host_rx", got, 8'h34);
      chk("ovw_rx_data", rx_data, 8'h9C);

      // Abort after 5 bits: rx buffer untouched.
      prev_rx = rx_data;
      spi_cs_n = 1'b0;
      half();
      xfer(1'b0, 8'hE7, 5, 1'b0, 8'h00, got);
      half();
      spi_cs_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("abort_rx_valid", {7'b0, rx_valid}, 8'h01);
      chk("abort_rx_data",  rx_data, prev_rx);
      chk("abort_busy",     {7'b0, busy}, 8'h00);
      chk("abort_overrun",  {7'b0, overrun}, 8'h00);
      pulse_rx_rd();
      frame(1'b0, 8'h77, got);
      chk("abort_next_rx", rx_data, 8'h77);
      chk("abort_next_host", got, 8'hFF);

      // Async reset mid-frame with state to clear.
      spi_cs_n = 1'b0;
      half();
      write_tx(8'hC0);
      xfer(1'b0, 8'hB0, 3, 1'b0, 8'h00, got);
      rst = 1'b1;
      #1;
      chk("mrst_tx_full",  {7'b0, tx_full},     8'h00);
      chk("mrst_rx_valid", {7'b0, rx_valid},    8'h00);
      chk("mrst_rx_data",  rx_data,             8'h00);
      chk("mrst_busy",     {7'b0, busy},        8'h00);
      chk("mrst_oe",       {7'b0, spi_miso_oe}, 8'h00);
      chk("mrst_miso",     {7'b0, spi_miso},    8'h01);
      spi_cs_n = 1'b1; spi_sck = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      write_tx(8'h96);
      frame(1'b0, 8'h3C, got);
      chk("post_rst_host", got, 8'h96);
      chk("post_rst_rx",   rx_data, 8'h3C);
      chk("post_rst_ovr",  {7'b0, overrun}, 8'h00);

`ifdef SPI_TARGET_MODE3_EN
      pulse_rx_rd();
      spi_sck = 1'b1;
      mode3 = 1'b1;
      repeat (6) @(negedge clk);
      write_tx(8'h5A);
      frame(1'b1, 8'hC3, got);
      chk("m3_rx_data", rx_data, 8'hC3);
      chk("m3_host_rx", got, 8'h5A);
      chk("m3_overrun", {7'b0, overrun}, 8'h00);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
